// File: rtl/pkt_merger.sv
// Packet-boundary merger of a data and a control AXI-Stream onto one registered output.
// Optional build macro CTRL_PRIORITY_EN: control wins every tie; otherwise ties alternate round-robin.
module pkt_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic                              c_s_axis_tlast,
    input  logic                              c_s_axis_tvalid,
    output logic                              c_s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,

    output logic [31:0]                       data_pkt_cnt,
    output logic [31:0]                       ctrl_pkt_cnt
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CTRL = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   last_grant_reg, last_grant_next;   // 1 = control was served last

    logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_reg;
    logic [KEEP_W-1:0]               tkeep_reg;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_reg;
    logic                            tlast_reg;
    logic                            tvalid_reg;
    logic                            src_reg;  // source of the beat held in the output register
    logic [31:0]                     data_pkt_cnt_reg;
    logic [31:0]                     ctrl_pkt_cnt_reg;

    logic out_ready;
    logic s_accept;
    logic c_accept;
    logic pkt_done;

    assign out_ready = ~tvalid_reg | m_axis_tready;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        s_axis_tready   = 1'b0;
        c_s_axis_tready = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s_axis_tvalid && c_s_axis_tvalid) begin
`ifdef CTRL_PRIORITY_EN
                    state_next = CTRL;
`else
                    state_next = last_grant_reg ? DATA : CTRL;
`endif
                end else if (s_axis_tvalid) begin
                    state_next = DATA;
                end else if (c_s_axis_tvalid) begin
                    state_next = CTRL;
                end
            end
            DATA: begin
                s_axis_tready = out_ready;
                if (s_axis_tvalid && out_ready && s_axis_tlast) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b0;
                end
            end
            CTRL: begin
                c_s_axis_tready = out_ready;
                if (c_s_axis_tvalid && out_ready && c_s_axis_tlast) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_accept = s_axis_tvalid & s_axis_tready;
    assign c_accept = c_s_axis_tvalid & c_s_axis_tready;
    assign pkt_done = tvalid_reg & m_axis_tready & tlast_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Only one grant is ever active, so c_accept alone selects the source.
    always_ff @(posedge clk) begin
        if (reset) begin
            tdata_reg  <= '0;
            tkeep_reg  <= '0;
            tuser_reg  <= '0;
            tlast_reg  <= 1'b0;
            tvalid_reg <= 1'b0;
            src_reg    <= 1'b0;
        end else if (s_accept || c_accept) begin
            tdata_reg  <= c_accept ? c_s_axis_tdata : s_axis_tdata;
            tkeep_reg  <= c_accept ? c_s_axis_tkeep : s_axis_tkeep;
            tuser_reg  <= c_accept ? c_s_axis_tuser : s_axis_tuser;
            tlast_reg  <= c_accept ? c_s_axis_tlast : s_axis_tlast;
            tvalid_reg <= 1'b1;
            src_reg    <= c_accept;
        end else if (m_axis_tready) begin
            tvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_pkt_cnt_reg <= '0;
            ctrl_pkt_cnt_reg <= '0;
        end else if (pkt_done) begin
            if (src_reg) begin
                ctrl_pkt_cnt_reg <= ctrl_pkt_cnt_reg + 32'd1;
            end else begin
                data_pkt_cnt_reg <= data_pkt_cnt_reg + 32'd1;
            end
        end
    end

    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tkeep  = tkeep_reg;
    assign m_axis_tuser  = tuser_reg;
    assign m_axis_tlast  = tlast_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign data_pkt_cnt  = data_pkt_cnt_reg;
    assign ctrl_pkt_cnt  = ctrl_pkt_cnt_reg;

endmodule

// File: tb/tb_pkt_merger.sv
// Bench for pkt_merger: directed scenarios plus randomized traffic against a per-source packet scoreboard.
module tb_pkt_merger;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] s_axis_tdata,  c_s_axis_tdata,  m_axis_tdata;
    logic [KW-1:0] s_axis_tkeep,  c_s_axis_tkeep,  m_axis_tkeep;
    logic [UW-1:0] s_axis_tuser,  c_s_axis_tuser,  m_axis_tuser;
    logic          s_axis_tlast,  c_s_axis_tlast,  m_axis_tlast;
    logic          s_axis_tvalid, c_s_axis_tvalid, m_axis_tvalid;
    logic          s_axis_tready, c_s_axis_tready, m_axis_tready;
    logic [31:0]   data_pkt_cnt,  ctrl_pkt_cnt;

    pkt_merger dut (
        .clk             (clk),
        .reset           (reset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .c_s_axis_tdata  (c_s_axis_tdata),
        .c_s_axis_tkeep  (c_s_axis_tkeep),
        .c_s_axis_tuser  (c_s_axis_tuser),
        .c_s_axis_tlast  (c_s_axis_tlast),
        .c_s_axis_tvalid (c_s_axis_tvalid),
        .c_s_axis_tready (c_s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .data_pkt_cnt    (data_pkt_cnt),
        .ctrl_pkt_cnt    (ctrl_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Drive queues (what each source still has to present) and scoreboard queues (what must come out).
    beat_t d_q[$], c_q[$], de_q[$], ce_q[$];
    int    out_cyc[$];
    bit    out_src[$];
    logic [31:0] cnt_d, cnt_c;
    bit    in_pkt, cur_src;
    bit    held_v;
    beat_t held;
    int    cyc = 0;
    int    d_prob = 100, c_prob = 100, r_prob = 100;
    int    stall_left = 0;
    bit    prio_watch = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic add_pkt(input bit src, input int len, input bit rnd, input logic [7:0] pat);
        beat_t b;
        logic [7:0] p;
        for (int i = 0; i < len; i++) begin
            p = pat * 8'(i + 1);
            if (rnd) begin
                for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
                for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
                b.keep = $urandom;
            end else begin
                b.data = {32{p}};
                b.keep = '1;
                b.user = {16{p}};
            end
            b.data[DW-1] = src;   // source tag travels in the top data bit
            b.last = (i == len - 1);
            if (src) begin
                c_q.push_back(b);
                ce_q.push_back(b);
            end else begin
                d_q.push_back(b);
                de_q.push_back(b);
            end
        end
    endtask

    task automatic out_beat();
        bit    src;
        beat_t e;
        src = m_axis_tdata[DW-1];
        out_cyc.push_back(cyc);
        out_src.push_back(src);
        if (in_pkt) check("no_interleave", src, cur_src);
        if ((src && ce_q.size() == 0) || (!src && de_q.size() == 0)) begin
            check("spurious_beat", 1, 0);
            return;
        end
        e = src ? ce_q.pop_front() : de_q.pop_front();
        check("beat_data", m_axis_tdata, e.data);
        check("beat_keep", m_axis_tkeep, e.keep);
        check("beat_user", m_axis_tuser, e.user);
        check("beat_last", m_axis_tlast, e.last);
        if (m_axis_tlast) begin
            in_pkt = 0;
            if (src) cnt_c++;
            else     cnt_d++;
        end else begin
            in_pkt  = 1;
            cur_src = src;
        end
    endtask

    task automatic cycle();
        logic d_fire, c_fire;
        @(negedge clk);
        d_fire = s_axis_tvalid & s_axis_tready;
        c_fire = c_s_axis_tvalid & c_s_axis_tready;
        if (d_fire) void'(d_q.pop_front());
        if (c_fire) void'(c_q.pop_front());
        check("excl_grant", s_axis_tready & c_s_axis_tready, 0);
        if (m_axis_tvalid && !m_axis_tready)
            check("stall_gate", s_axis_tready | c_s_axis_tready, 0);
`ifdef CTRL_PRIORITY_EN
        if (prio_watch && c_q.size() > 0) check("prio_s_ready", s_axis_tready, 0);
`endif
        if (held_v) begin
            check("stable_valid", m_axis_tvalid, 1);
            check("stable_data", m_axis_tdata, held.data);
            check("stable_keep", m_axis_tkeep, held.keep);
            check("stable_user", m_axis_tuser, held.user);
            check("stable_last", m_axis_tlast, held.last);
        end
        held_v    = m_axis_tvalid & ~m_axis_tready;
        held.data = m_axis_tdata;
        held.keep = m_axis_tkeep;
        held.user = m_axis_tuser;
        held.last = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) out_beat();
        @(posedge clk);
        cyc++;
        #1;
        if (!(s_axis_tvalid && !d_fire))
            s_axis_tvalid = (d_q.size() > 0) && ($urandom_range(0, 99) < d_prob);
        if (!(c_s_axis_tvalid && !c_fire))
            c_s_axis_tvalid = (c_q.size() > 0) && ($urandom_range(0, 99) < c_prob);
        if (d_q.size() > 0) begin
            s_axis_tdata = d_q[0].data; s_axis_tkeep = d_q[0].keep;
            s_axis_tuser = d_q[0].user; s_axis_tlast = d_q[0].last;
        end
        if (c_q.size() > 0) begin
            c_s_axis_tdata = c_q[0].data; c_s_axis_tkeep = c_q[0].keep;
            c_s_axis_tuser = c_q[0].user; c_s_axis_tlast = c_q[0].last;
        end
        if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
        end else begin
            m_axis_tready = ($urandom_range(0, 99) < r_prob);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((d_q.size() + c_q.size() + de_q.size() + ce_q.size()) > 0 && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) check("drain_timeout", 1, 0);
        cycle();
        cycle();
    endtask

    task automatic clear_model();
        d_q.delete(); c_q.delete(); de_q.delete(); ce_q.delete();
        out_cyc.delete(); out_src.delete();
        cnt_d = 0; cnt_c = 0; in_pkt = 0; held_v = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b0; c_s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_model();
    endtask

    initial begin
        int t0, n;
        reset = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        c_s_axis_tdata = '0; c_s_axis_tkeep = '0; c_s_axis_tuser = '0; c_s_axis_tlast = 1'b0; c_s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        clear_model();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_s_ready", s_axis_tready, 0);
        check("rst_c_ready", c_s_axis_tready, 0);
        check("rst_dcnt", data_pkt_cnt, 0);
        check("rst_ccnt", ctrl_pkt_cnt, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single 3-beat data packet: latency 2, then 1 beat/cycle
        add_pkt(0, 3, 0, 8'h11);
        cycle();
        t0 = cyc;
        drain(100);
        check("single_beats", out_cyc.size(), 3);
        for (int i = 0; i < 3 && i < out_cyc.size(); i++)
            check("single_latency", out_cyc[i] - t0, 2 + i);
        check("single_dcnt", data_pkt_cnt, 1);
        check("single_ccnt", ctrl_pkt_cnt, 0);

        // Tie between both sources, 2 packets each of 2 beats
        do_reset();
        add_pkt(0, 2, 0, 8'h21);
        add_pkt(0, 2, 0, 8'h31);
        add_pkt(1, 2, 0, 8'h41);
        add_pkt(1, 2, 0, 8'h51);
        prio_watch = 1;
        cycle();
        t0 = cyc;
        drain(200);
        prio_watch = 0;
        check("tie_beats", out_src.size(), 8);
        for (int i = 0; i < 8 && i < out_src.size(); i++) begin
`ifdef CTRL_PRIORITY_EN
            check("tie_order", out_src[i], (i < 4) ? 1 : 0);
`else
            check("tie_order", out_src[i], (i / 2) % 2);
`endif
            check("tie_cycle", out_cyc[i] - t0, 2 + i + i / 2);
        end
        check("tie_dcnt", data_pkt_cnt, 2);
        check("tie_ccnt", ctrl_pkt_cnt, 2);

        // Backpressure for 5 cycles mid-packet
        out_src.delete(); out_cyc.delete();
        add_pkt(0, 6, 1, 8'h00);
        n = 0;
        while (out_src.size() < 2 && n < 50) begin cycle(); n++; end
        check("bp_reach_mid", out_src.size() >= 2, 1);
        stall_left = 5;
        drain(200);
        check("bp_beats", out_src.size(), 6);
        check("bp_dcnt", data_pkt_cnt, cnt_d);

        // Reset asserted during beat 2 of a 4-beat packet
        add_pkt(0, 4, 1, 8'h00);
        n = 0;
        while (d_q.size() > 3 && n < 50) begin cycle(); n++; end
        check("rstmid_reach", d_q.size(), 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_tvalid", m_axis_tvalid, 0);
        check("rstmid_s_ready", s_axis_tready, 0);
        check("rstmid_c_ready", c_s_axis_tready, 0);
        check("rstmid_dcnt", data_pkt_cnt, 0);
        check("rstmid_ccnt", ctrl_pkt_cnt, 0);
        s_axis_tvalid = 1'b0;
        c_s_axis_tvalid = 1'b0;
        clear_model();

        // Randomized traffic with gaps and backpressure
        for (int p = 0; p < 30; p++) begin
            add_pkt(0, $urandom_range(1, 4), 1, 8'h00);
            add_pkt(1, $urandom_range(1, 4), 1, 8'h00);
        end
        d_prob = 60; c_prob = 60; r_prob = 70;
        drain(5000);
        d_prob = 100; c_prob = 100; r_prob = 100;
        check("rand_dcnt", data_pkt_cnt, cnt_d);
        check("rand_ccnt", ctrl_pkt_cnt, cnt_c);
        check("rand_total", cnt_d + cnt_c, 60);

        // Counter wrap
        force dut.data_pkt_cnt_reg = 32'hFFFF_FFFF;
        #1 release dut.data_pkt_cnt_reg;
        cnt_d = 32'hFFFF_FFFF;
        add_pkt(0, 1, 1, 8'h00);
        drain(100);
        check("wrap_dcnt", data_pkt_cnt, 0);
        check("wrap_model", data_pkt_cnt, cnt_d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
